// File: rtl/bus_bridge_resp.sv
// CPU data-bus responder: RAM, LED, switches, buttons, 7-seg display, timer.
// Define IO_SYNC_EN to pass sw/button through two-flop synchronizers.
module bus_bridge_resp #(
   parameter int SCAN_DIV = 20000,
   parameter int TMR_DIV  = 25000
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [31:0] Dram_addr,
   input  logic        Dram_we,
   input  logic [31:0] Dram_wdata,
   output logic [31:0] Dram_rdata,
   output logic [13:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic [23:0] sw,
   input  logic [4:0]  button,
   output logic [23:0] led,
   output logic [7:0]  dig_en,
   output logic [7:0]  dig_seg
);
   localparam int SPW = $clog2(SCAN_DIV);
   localparam int TPW = $clog2(TMR_DIV);

   localparam logic [31:0] A_DIG = 32'hFFFF_F000;
   localparam logic [31:0] A_TMR = 32'hFFFF_F020;
   localparam logic [31:0] A_LED = 32'hFFFF_F060;
   localparam logic [31:0] A_SW  = 32'hFFFF_F070;
   localparam logic [31:0] A_BTN = 32'hFFFF_F078;

   logic           periph;
   logic           sel_dig, sel_tmr, sel_led, sel_sw, sel_btn;
   logic [31:0]    dig_val;
   logic [31:0]    tmr_cnt;
   logic [TPW-1:0] tmr_pre;
   logic [SPW-1:0] scan_pre;
   logic [2:0]     scan_idx;
   logic [23:0]    sw_s;
   logic [4:0]     btn_s;

   assign periph  = Dram_addr[31:12] == 20'hFFFFF;
   assign sel_dig = Dram_addr == A_DIG;
   assign sel_tmr = Dram_addr == A_TMR;
   assign sel_led = Dram_addr == A_LED;
   assign sel_sw  = Dram_addr == A_SW;
   assign sel_btn = Dram_addr == A_BTN;

   assign ram_addr  = Dram_addr[15:2];
   assign ram_wdata = Dram_wdata;
   assign ram_we    = Dram_we & ~periph;

   always_comb begin
      Dram_rdata = '0;
      unique case (1'b1)
         !periph: Dram_rdata = ram_rdata;
         sel_dig: Dram_rdata = dig_val;
         sel_tmr: Dram_rdata = tmr_cnt;
         sel_led: Dram_rdata = {8'h0, led};
         sel_sw:  Dram_rdata = {8'h0, sw_s};
         sel_btn: Dram_rdata = {27'h0, btn_s};
         default: Dram_rdata = '0;
      endcase
   end

`ifdef IO_SYNC_EN
   logic [23:0] sw_q;
   logic [4:0]  btn_q;

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         sw_q  <= '0;
         sw_s  <= '0;
         btn_q <= '0;
         btn_s <= '0;
      end else begin
         sw_q  <= sw;
         sw_s  <= sw_q;
         btn_q <= button;
         btn_s <= btn_q;
      end
   end
`else
   assign sw_s  = sw;
   assign btn_s = button;
`endif

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         dig_val <= '0;
         led     <= '0;
      end else begin
         if (Dram_we && sel_dig) dig_val <= Dram_wdata;
         if (Dram_we && sel_led) led <= Dram_wdata[23:0];
      end
   end

   // A CPU load of the timer beats a coincident prescaler wrap
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         tmr_pre <= '0;
         tmr_cnt <= '0;
      end else if (Dram_we && sel_tmr) begin
         tmr_pre <= '0;
         tmr_cnt <= Dram_wdata;
      end else if (tmr_pre == TPW'(TMR_DIV - 1)) begin
         tmr_pre <= '0;
         tmr_cnt <= tmr_cnt + 32'd1;
      end else begin
         tmr_pre <= tmr_pre + TPW'(1);
      end
   end

   function automatic logic [7:0] seg7(input logic [3:0] h);
      logic [7:0] s;
      s = 8'hFF;
      unique case (h)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         4'hF: s = 8'h8E;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // Outputs are registered from scan_idx/dig_val so pads never glitch
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         scan_pre <= '0;
         scan_idx <= '0;
         dig_en   <= 8'hFE;
         dig_seg  <= 8'hC0;
      end else begin
         dig_en  <= ~(8'b1 << scan_idx);
         dig_seg <= seg7(dig_val[{scan_idx, 2'b00} +: 4]);
         if (scan_pre == SPW'(SCAN_DIV - 1)) begin
            scan_pre <= '0;
            scan_idx <= scan_idx + 3'd1;
         end else begin
            scan_pre <= scan_pre + SPW'(1);
         end
      end
   end

endmodule
